// File: rtl/writeback_arbiter_if.sv
// Handshake and register-file bundle between the ALU/LSU result producers,
// the write-back arbiter, the register-file write port and decode.
interface writeback_arbiter_if;
  // ALU result port
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  // Load/store result port
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_result;
  // Register-file write port
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] result;
  // Decode operand pending lookup
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;

  // Producer/decode side
  modport master (
    output alu_valid, alu_rd, alu_result,
    output lsu_valid, lsu_rd, lsu_result,
    output rs1, rs2,
    input  alu_ready, lsu_ready,
    input  wr_en, rd, result,
    input  rs1_busy, rs2_busy
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  lsu_valid, lsu_rd, lsu_result,
    input  rs1, rs2,
    output alu_ready, lsu_ready,
    output wr_en, rd, result,
    output rs1_busy, rs2_busy
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: one holding slot per result source, age-then-round-robin
// arbitration into the single register-file write port, plus pending-write
// lookup for decode operands.
module writeback_arbiter (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.slave  bus
);

  // Holding slots
  logic        alu_v_q, alu_v_d;
  logic [4:0]  alu_rd_q, alu_rd_d;
  logic [31:0] alu_data_q, alu_data_d;
  logic        alu_old_q, alu_old_d;
  logic        lsu_v_q, lsu_v_d;
  logic [4:0]  lsu_rd_q, lsu_rd_d;
  logic [31:0] lsu_data_q, lsu_data_d;
  logic        lsu_old_q, lsu_old_d;
  // Round-robin pointer: 1 prefers the LSU on a same-age tie
  logic        ptr_lsu_q, ptr_lsu_d;
  // Registered write port
  logic        wr_en_q, wr_en_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;

  logic grant_alu, grant_lsu, tie;
  logic alu_ready, lsu_ready;
  logic alu_load, lsu_load;
  logic alu_keep, lsu_keep;

  // Arbitration: single valid slot wins; otherwise older wins; otherwise pointer
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    tie       = 1'b0;
    if (alu_v_q && lsu_v_q) begin
      if (alu_old_q && !lsu_old_q) begin
        grant_alu = 1'b1;
      end else if (lsu_old_q && !alu_old_q) begin
        grant_lsu = 1'b1;
      end else begin
        tie = 1'b1;
        if (ptr_lsu_q) grant_lsu = 1'b1;
        else           grant_alu = 1'b1;
      end
    end else begin
      grant_alu = alu_v_q;
      grant_lsu = lsu_v_q;
    end
  end

  // Ready depends only on slot occupancy and this cycle's grant, never on valid
  assign alu_ready = !rst && (!alu_v_q || grant_alu);
  assign lsu_ready = !rst && (!lsu_v_q || grant_lsu);
  // x0 writes complete the handshake but never occupy a slot
  assign alu_load  = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
  assign lsu_load  = bus.lsu_valid && lsu_ready && (bus.lsu_rd != 5'd0);
  // A slot that holds an entry across this edge
  assign alu_keep  = alu_v_q && !grant_alu;
  assign lsu_keep  = lsu_v_q && !grant_lsu;

  // Next-state for slots, age flags, pointer and the write-port register
  always_comb begin
    alu_v_d    = alu_load || alu_keep;
    alu_rd_d   = alu_load ? bus.alu_rd : alu_rd_q;
    alu_data_d = alu_load ? bus.alu_result : alu_data_q;
    // A waiting entry becomes older once the other slot loads behind it
    alu_old_d  = alu_keep ? (alu_old_q || lsu_load) : 1'b0;

    lsu_v_d    = lsu_load || lsu_keep;
    lsu_rd_d   = lsu_load ? bus.lsu_rd : lsu_rd_q;
    lsu_data_d = lsu_load ? bus.lsu_result : lsu_data_q;
    lsu_old_d  = lsu_keep ? (lsu_old_q || alu_load) : 1'b0;

    ptr_lsu_d  = tie ? !ptr_lsu_q : ptr_lsu_q;

    wr_en_d    = grant_alu || grant_lsu;
    rd_d       = rd_q;
    result_d   = result_q;
    if (grant_lsu) begin
      rd_d     = lsu_rd_q;
      result_d = lsu_data_q;
    end else if (grant_alu) begin
      rd_d     = alu_rd_q;
      result_d = alu_data_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_v_q    <= 1'b0;
      alu_rd_q   <= 5'd0;
      alu_data_q <= 32'd0;
      alu_old_q  <= 1'b0;
      lsu_v_q    <= 1'b0;
      lsu_rd_q   <= 5'd0;
      lsu_data_q <= 32'd0;
      lsu_old_q  <= 1'b0;
      ptr_lsu_q  <= 1'b1;
      wr_en_q    <= 1'b0;
      rd_q       <= 5'd0;
      result_q   <= 32'd0;
    end else begin
      alu_v_q    <= alu_v_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      alu_old_q  <= alu_old_d;
      lsu_v_q    <= lsu_v_d;
      lsu_rd_q   <= lsu_rd_d;
      lsu_data_q <= lsu_data_d;
      lsu_old_q  <= lsu_old_d;
      ptr_lsu_q  <= ptr_lsu_d;
      wr_en_q    <= wr_en_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
    end
  end

  // Pending-write lookup; the output stage counts because the register file
  // commits only at the edge that ends the wr_en cycle
  function automatic logic pending(input logic [4:0] idx);
    return (idx != 5'd0) &&
           ((alu_v_q && alu_rd_q == idx) ||
            (lsu_v_q && lsu_rd_q == idx) ||
            (wr_en_q && rd_q == idx));
  endfunction

  assign bus.alu_ready = alu_ready;
  assign bus.lsu_ready = lsu_ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.rd        = rd_q;
  assign bus.result    = result_q;
  // Held low during reset so decode sees the cleared state immediately
  assign bus.rs1_busy  = !rst && pending(bus.rs1);
  assign bus.rs2_busy  = !rst && pending(bus.rs2);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
module tb_writeback_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  writeback_arbiter_if bus ();

  writeback_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".wr_en"}, {31'd0, bus.wr_en}, {31'd0, en});
    if (en) begin
      chk({tag, ".rd"}, {27'd0, bus.rd}, {27'd0, r});
      chk({tag, ".result"}, bus.result, d);
    end
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] r, input logic [31:0] d);
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = r;
    bus.alu_result = d;
  endtask

  task automatic drive_lsu(input logic [4:0] r, input logic [31:0] d);
    bus.lsu_valid  = 1'b1;
    bus.lsu_rd     = r;
    bus.lsu_result = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_result = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_result = 32'd0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;

    // Reset state
    tick();
    tick();
    chk("rst.wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rst.rd", {27'd0, bus.rd}, 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    chk("rst.lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("post_rst.lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);

    // Single ALU write, latency and busy window
    drive_alu(5'd5, 32'hDEADBEEF);
    bus.rs1 = 5'd5;
    tick();
    idle();
    #1;
    chk("t1.c1.rs1_busy", {31'd0, bus.rs1_busy}, 32'd1);
    chk_wr("t1.c1", 1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("t1.c2", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("t1.c2.rs1_busy", {31'd0, bus.rs1_busy}, 32'd1);
    tick();
    chk_wr("t1.c3", 1'b0, 5'd0, 32'd0);
    chk("t1.c3.rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);

    // Tie from reset pointer: LSU first, then ALU
    drive_alu(5'd3, 32'h11);
    drive_lsu(5'd4, 32'h22);
    bus.rs2 = 5'd4;
    tick();
    idle();
    #1;
    chk("t2.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    chk("t2.lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    chk("t2.rs2_busy", {31'd0, bus.rs2_busy}, 32'd1);
    tick();
    chk_wr("t2.w1", 1'b1, 5'd4, 32'h22);
    tick();
    chk_wr("t2.w2", 1'b1, 5'd3, 32'h11);
    tick();
    chk_wr("t2.idle", 1'b0, 5'd0, 32'd0);

    // Repeat tie: pointer now prefers ALU
    drive_alu(5'd10, 32'hA);
    drive_lsu(5'd11, 32'hB);
    tick();
    idle();
    tick();
    chk_wr("t2b.w1", 1'b1, 5'd10, 32'hA);
    tick();
    chk_wr("t2b.w2", 1'b1, 5'd11, 32'hB);
    tick();
    chk_wr("t2b.idle", 1'b0, 5'd0, 32'd0);

    // Age beats pointer: tie (LSU wins, pointer -> ALU), ALU becomes older,
    // then LSU entry waits while ALU loads rd 7; older LSU goes first
    drive_alu(5'd12, 32'hC);
    drive_lsu(5'd13, 32'hD);
    tick();
    bus.alu_valid = 1'b0;
    drive_lsu(5'd14, 32'h14);
    #1;
    chk("t3.p.lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    chk("t3.p.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    tick();
    chk_wr("t3.w1", 1'b1, 5'd13, 32'hD);
    bus.lsu_valid = 1'b0;
    drive_alu(5'd7, 32'h77);
    #1;
    chk("t3.p1.alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    tick();
    idle();
    chk_wr("t3.w2", 1'b1, 5'd12, 32'hC);
    tick();
    chk_wr("t3.w3", 1'b1, 5'd14, 32'h14);
    tick();
    chk_wr("t3.w4", 1'b1, 5'd7, 32'h77);
    tick();
    chk_wr("t3.idle", 1'b0, 5'd0, 32'd0);

    // ALU stream rd 1..8, LSU idle
    for (int i = 1; i <= 8; i++) begin
      drive_alu(5'(i), 32'h101 * i);
      #1;
      chk($sformatf("t4.ready%0d", i), {31'd0, bus.alu_ready}, 32'd1);
      tick();
      if (i > 1) chk_wr($sformatf("t4.w%0d", i - 1), 1'b1, 5'(i - 1), 32'h101 * (i - 1));
    end
    idle();
    tick();
    chk_wr("t4.w8", 1'b1, 5'd8, 32'h808);
    tick();
    chk_wr("t4.idle", 1'b0, 5'd0, 32'd0);

    // x0 write is accepted and discarded
    drive_alu(5'd0, 32'hFFFFFFFF);
    bus.rs1 = 5'd0;
    #1;
    chk("t5.alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("t5.c0.rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
    tick();
    idle();
    #1;
    chk_wr("t5.c1", 1'b0, 5'd0, 32'd0);
    chk("t5.c1.rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
    tick();
    chk_wr("t5.c2", 1'b0, 5'd0, 32'd0);
    chk("t5.c2.rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);

    // Reset with both slots full
    drive_alu(5'd21, 32'h2121);
    drive_lsu(5'd22, 32'h2222);
    bus.rs1 = 5'd21;
    bus.rs2 = 5'd22;
    tick();
    idle();
    #1;
    chk("t6.full.rs1_busy", {31'd0, bus.rs1_busy}, 32'd1);
    chk("t6.full.rs2_busy", {31'd0, bus.rs2_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6.rst.rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
    chk("t6.rst.rs2_busy", {31'd0, bus.rs2_busy}, 32'd0);
    chk("t6.rst.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    tick();
    chk("t6.after.wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("t6.after.rd", {27'd0, bus.rd}, 32'd0);
    chk("t6.after.rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("t6.rel.rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
    chk("t6.rel.rs2_busy", {31'd0, bus.rs2_busy}, 32'd0);
    tick();
    chk("t6.rel1.wr_en", {31'd0, bus.wr_en}, 32'd0);
    tick();
    chk("t6.rel2.wr_en", {31'd0, bus.wr_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
